rx_stream_monitor: RTL

- Sits directly downstream of the receive stage and consumes its 9-bit data word and data_valid flag every clock.
- Checks that the word stream is a legal transmit-counter progression: hold, increment, wrap, or clear-to-zero.
- Counts parity failures and sequence errors, and runs a lock/alarm state machine.
- Drives the link-status outputs for the channel.

---
 rtl/rx_stream_monitor_pkg.sv | 11 +
 rtl/rx_stream_monitor_sat_counter.sv | 19 +
 rtl/rx_stream_monitor.sv | 119 +++++++++++
 3 files changed

// File: rtl/rx_stream_monitor_pkg.sv
// Shared constants for the receive-stream monitor: state encodings and the
// data width shared with the transmit counter and receive stage.
package rx_stream_monitor_pkg;

  localparam int DATA_W_DEF = 9;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_ALARM  = 2'd2;

endpackage

// File: rtl/rx_stream_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rx_stream_monitor.sv
// Checks the received word stream is a legal transmit-counter progression and
// runs the SEARCH -> LOCKED -> ALARM link-status state machine.
module rx_stream_monitor
  import rx_stream_monitor_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = 8,
  parameter int LOCK_LEN  = 4,
  parameter int ALARM_LEN = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              locked,
  output logic              alarm,
  output logic [DATA_W-1:0] last_good,
  output logic [CNT_W-1:0]  parity_err_cnt,
  output logic [CNT_W-1:0]  seq_err_cnt,
  output logic [1:0]        state_dbg
);

  localparam int RUN_W  = $clog2(LOCK_LEN + 1);
  localparam int MISS_W = $clog2(ALARM_LEN + 1);

  logic [1:0]        state;
  logic [RUN_W-1:0]  run;
  logic [MISS_W-1:0] miss;
  logic              ref_ok;

  logic [MISS_W-1:0] miss_eff;
  logic [DATA_W-1:0] delta;
  logic [DATA_W-1:0] limit;
  logic              legal;
  logic              parity_inc;
  logic              seq_inc;

  // Forward distance modulo 2^DATA_W; up to miss+1 tolerates words lost to parity.
  always_comb begin
    miss_eff   = (state == ST_LOCKED) ? miss : '0;
    delta      = data_in - last_good;
    limit      = DATA_W'(miss_eff) + DATA_W'(1);
    legal      = (data_in == '0) || (delta <= limit);
    parity_inc = !data_valid;
    seq_inc    = (state == ST_LOCKED) && data_valid && !legal;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= ST_SEARCH;
      run       <= '0;
      miss      <= '0;
      ref_ok    <= 1'b0;
      last_good <= '0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (!data_valid) begin
            run    <= '0;
            ref_ok <= 1'b0;
          end else if (!ref_ok) begin
            last_good <= data_in;
            ref_ok    <= 1'b1;
            run       <= RUN_W'(1);
          end else if (legal) begin
            last_good <= data_in;
            if (run == RUN_W'(LOCK_LEN - 1)) begin
              state <= ST_LOCKED;
              miss  <= '0;
              run   <= '0;
            end else begin
              run <= run + RUN_W'(1);
            end
          end else begin
            // An illegal word becomes the new reference; no error is counted here.
            last_good <= data_in;
            run       <= RUN_W'(1);
          end
        end
        ST_LOCKED: begin
          if (data_valid && legal) begin
            last_good <= data_in;
            miss      <= '0;
          end else begin
            if (miss == MISS_W'(ALARM_LEN - 1)) begin
              state <= ST_ALARM;
            end
            miss <= miss + MISS_W'(1);
          end
        end
        ST_ALARM: begin
          state <= ST_ALARM;
        end
        default: begin
          state <= ST_SEARCH;
        end
      endcase
    end
  end

  assign locked    = (state == ST_LOCKED);
  assign alarm     = (state == ST_ALARM);
  assign state_dbg = state;

  sat_counter #(.CNT_W(CNT_W)) u_parity_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (parity_inc),
    .count (parity_err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_seq_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (seq_inc),
    .count (seq_err_cnt)
  );

endmodule
